caminho_dados: RTL



---
 rtl/caminho_dados_if.sv | 28 ++
 rtl/caminho_dados.sv | 82 ++++++++
 2 files changed

// File: rtl/caminho_dados_if.sv
// Control-to-datapath bundle: strobes from the instruction FSM in, result and status out.
// master = control FSM / bench side, slave = datapath side.
interface caminho_dados_if #(
    parameter int N = 8,
    parameter int W = N + 2
);
    logic signed [N-1:0] Entrada;
    logic                EnA;
    logic                EnB;
    logic                Sel;
    logic [1:0]          Op;
    logic [1:0]          OpReg;
    logic                Fim;
    logic [W-1:0]        Resultado;
    logic                Valido;
    logic                Zero;
    logic                Negativo;

    modport master (
        output Entrada, EnA, EnB, Sel, Op, OpReg, Fim,
        input  Resultado, Valido, Zero, Negativo
    );

    modport slave (
        input  Entrada, EnA, EnB, Sel, Op, OpReg, Fim,
        output Resultado, Valido, Zero, Negativo
    );
endinterface

// File: rtl/caminho_dados.sv
// Operand registers A/B, signed ALU and result register R driven by control-FSM strobes.
// R, flags and Valido are registered (one edge after the strobe); no backpressure, a step is accepted every cycle.
module caminho_dados #(
    parameter int N = 8,
    parameter int W = N + 2
) (
    input  logic            clk,
    input  logic            rst,
    caminho_dados_if.slave  bus
);
    localparam logic [1:0] OP_ZERO = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    localparam logic [1:0] RG_HOLD = 2'b00;
    localparam logic [1:0] RG_LOAD = 2'b01;
    localparam logic [1:0] RG_HALF = 2'b10;

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_r;
    logic         r_valido;
    logic         r_zero;
    logic         r_negativo;

    logic [W-1:0] w_entrada_ext;
    logic [W-1:0] w_y;
    logic [W-1:0] w_f;
    logic [W-1:0] w_r_next;

    assign w_entrada_ext = {{(W-N){bus.Entrada[N-1]}}, bus.Entrada};
    assign w_y           = bus.Sel ? r_r : r_b;

    always_comb begin
        w_f = '0;
        case (bus.Op)
            OP_ZERO: w_f = '0;
            OP_ADD:  w_f = r_a + w_y;
            OP_SUB:  w_f = r_a - w_y;
            default: w_f = r_a;
        endcase
    end

    // Halving replicates the sign bit so negative odd values round toward -inf.
    always_comb begin
        w_r_next = r_r;
        case (bus.OpReg)
            RG_HOLD: w_r_next = r_r;
            RG_LOAD: w_r_next = w_f;
            RG_HALF: w_r_next = {w_f[W-1], w_f[W-1:1]};
            default: w_r_next = '0;
        endcase
    end

    // Flags are derived from the next R so they always match the registered Resultado.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_r        <= '0;
            r_valido   <= 1'b0;
            r_zero     <= 1'b1;
            r_negativo <= 1'b0;
        end else begin
            if (bus.EnA) begin
                r_a <= w_entrada_ext;
            end
            if (bus.EnB) begin
                r_b <= w_entrada_ext;
            end
            r_r        <= w_r_next;
            r_zero     <= (w_r_next == '0);
            r_negativo <= w_r_next[W-1];
            r_valido   <= bus.Fim;
        end
    end

    assign bus.Resultado = r_r;
    assign bus.Valido    = r_valido;
    assign bus.Zero      = r_zero;
    assign bus.Negativo  = r_negativo;
endmodule
